// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin bus arbiter with snoop broadcast, sticky response collection and memory handshake.
// Define SNOOP_TIMEOUT_EN to build in the snoop timeout counter and the sticky snoop_to flag.
module snoop_bus_ctrl #(
    parameter int unsigned NCORES = 2,
    parameter int unsigned TO_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCORES-1:0] req,
    input  logic [NCORES-1:0] req_wr,
    input  logic [NCORES-1:0] req_inv,
    input  logic [NCORES-1:0] req_nodata,
    output logic [NCORES-1:0] gnt,
    output logic [NCORES-1:0] snoop_out,
    output logic              snoop_inv,
    input  logic [NCORES-1:0] snoop_hit_in,
    input  logic [NCORES-1:0] snoop_dirty_in,
    input  logic [NCORES-1:0] snoop_ready_in,
    output logic              mem_cs,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    output logic [NCORES-1:0] done,
    output logic              shared,
    output logic              c2c,
    output logic              snoop_to
);
    localparam int unsigned       IW  = $clog2(NCORES);
    localparam logic [NCORES-1:0] ONE = {{(NCORES-1){1'b0}}, 1'b1};

    if (NCORES < 2 || NCORES > 8) begin : g_bad_ncores
        $error("snoop_bus_ctrl: NCORES must be 2..8");
    end
    if (TO_CYC < 1 || TO_CYC > 255) begin : g_bad_to_cyc
        $error("snoop_bus_ctrl: TO_CYC must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, DONE} state_t;

    state_t            state_q;
    logic [IW-1:0]     owner_q, rr_q;
    logic              nodata_q;
    logic [NCORES-1:0] rdy_q, hit_q, dirty_q;
    logic [NCORES-1:0] gnt_q, snp_q, done_q;
    logic              snp_inv_q, mem_cs_q, mem_rd_q, mem_wr_q, shared_q, c2c_q;

    logic [IW-1:0]     pick_idx, cand;
    logic              pick_vld;
    logic [NCORES-1:0] pick_oh, own_mask, hit_eff, dirty_eff;
    logic              all_rdy, to_hit;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            cand = IW'((32'(rr_q) + i) % NCORES);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick_oh  = ONE << pick_idx;
    assign own_mask = ONE << owner_q;
    assign all_rdy  = &(rdy_q | own_mask);
    // Cores that never became ready are treated as miss/clean.
    assign hit_eff   = hit_q & rdy_q & ~own_mask;
    assign dirty_eff = dirty_q & rdy_q & ~own_mask;

`ifdef SNOOP_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       snoop_to_q;

    assign to_hit = (state_q == SNOOP) && !all_rdy && (to_cnt_q == 8'(TO_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q   <= '0;
            snoop_to_q <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == SNOOP) ? to_cnt_q + 8'd1 : '0;
            if (to_hit) snoop_to_q <= 1'b1;
        end
    end

    assign snoop_to = snoop_to_q;
`else
    assign to_hit   = 1'b0;
    assign snoop_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            nodata_q  <= 1'b0;
            rdy_q     <= '0;
            hit_q     <= '0;
            dirty_q   <= '0;
            gnt_q     <= '0;
            snp_q     <= '0;
            done_q    <= '0;
            snp_inv_q <= 1'b0;
            mem_cs_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            shared_q  <= 1'b0;
            c2c_q     <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        owner_q  <= pick_idx;
                        gnt_q    <= pick_oh;
                        nodata_q <= req_nodata[pick_idx];
                        rdy_q    <= '0;
                        hit_q    <= '0;
                        dirty_q  <= '0;
                        if (req_wr[pick_idx]) begin
                            state_q  <= MEM;
                            mem_cs_q <= 1'b1;
                            mem_wr_q <= 1'b1;
                        end else begin
                            state_q   <= SNOOP;
                            snp_q     <= ~pick_oh;
                            snp_inv_q <= req_inv[pick_idx];
                        end
                    end
                end
                SNOOP: begin
                    // Collection stops in the exit cycle so later stages see a frozen response set.
                    if (all_rdy || to_hit) begin
                        snp_q     <= '0;
                        snp_inv_q <= 1'b0;
                        if (nodata_q || (|dirty_eff)) begin
                            state_q  <= DONE;
                            done_q   <= gnt_q;
                            shared_q <= |hit_eff;
                            c2c_q    <= !nodata_q;
                        end else begin
                            state_q  <= MEM;
                            mem_cs_q <= 1'b1;
                            mem_rd_q <= 1'b1;
                        end
                    end else begin
                        rdy_q   <= rdy_q   | (snoop_ready_in & ~own_mask);
                        hit_q   <= hit_q   | (snoop_hit_in   & ~own_mask);
                        dirty_q <= dirty_q | (snoop_dirty_in & ~own_mask);
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        state_q  <= DONE;
                        mem_cs_q <= 1'b0;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        done_q   <= gnt_q;
                        shared_q <= |hit_eff;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    gnt_q    <= '0;
                    shared_q <= 1'b0;
                    c2c_q    <= 1'b0;
                    rr_q     <= (owner_q == IW'(NCORES - 1)) ? '0 : owner_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign snoop_out = snp_q;
    assign snoop_inv = snp_inv_q;
    assign mem_cs    = mem_cs_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign done      = done_q;
    assign shared    = shared_q;
    assign c2c       = c2c_q;
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl: transaction-level model of arbitration, snoop outcome and memory use.
// Timeout scenarios are exercised only when SNOOP_TIMEOUT_EN is defined.
module tb_snoop_bus_ctrl;
    localparam int NC    = 4;
    localparam int TO    = 3;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] req, req_wr, req_inv, req_nodata;
    logic [NC-1:0] gnt, snoop_out, done;
    logic [NC-1:0] snoop_hit_in, snoop_dirty_in, snoop_ready_in;
    logic          snoop_inv, mem_cs, mem_rd, mem_wr, mem_ready, shared, c2c, snoop_to;

    snoop_bus_ctrl #(.NCORES(NC), .TO_CYC(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_inv(req_inv),
        .req_nodata(req_nodata), .gnt(gnt), .snoop_out(snoop_out), .snoop_inv(snoop_inv),
        .snoop_hit_in(snoop_hit_in), .snoop_dirty_in(snoop_dirty_in),
        .snoop_ready_in(snoop_ready_in), .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .done(done), .shared(shared), .c2c(c2c), .snoop_to(snoop_to)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          exp_rr = 0;
    bit          exp_to = 1'b0;
    int          lat [NC];
    bit          hit_cfg [NC];
    bit          dirty_cfg [NC];
    int          mem_lat = 0;
    bit          owner_junk = 1'b0;

    task automatic set_req(input logic [NC-1:0] r, w, iv, nd);
        req = r; req_wr = w; req_inv = iv; req_nodata = nd;
    endtask

    task automatic set_resp(input int l0, l1, l2, l3, input logic [NC-1:0] h, d, input int ml);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
        for (int i = 0; i < NC; i++) begin
            hit_cfg[i]   = h[i] | d[i];
            dirty_cfg[i] = d[i];
        end
        mem_lat = ml;
    endtask

    // Runs one transaction from an IDLE negedge with req already driven; ends on the following IDLE negedge.
    task automatic do_txn(input bit keep_req, input bit drop_owner);
        int            o = -1;
        logic [NC-1:0] eg, esnp;
        bit            e_mem, e_wr, e_c2c, e_sh, timed, dty, inv_o, seen_done;
        int            e_snp, maxlat, cyc, snp, mcs, bad_gnt, bad_snp, bad_mem, bad_flg;
        for (int i = 0; i < NC; i++)
            if (o < 0 && req[(exp_rr + i) % NC]) o = (exp_rr + i) % NC;
        if (o < 0) o = 0;
        eg = '0; eg[o] = 1'b1; esnp = ~eg; inv_o = req_inv[o];
        e_mem = 0; e_wr = 0; e_c2c = 0; e_sh = 0; timed = 0; dty = 0; e_snp = 0; maxlat = 0;
        if (req_wr[o]) begin
            e_mem = 1; e_wr = 1;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (i != o) begin
                    if (lat[i] >= NEVER) timed = 1;
                    else begin
                        if (lat[i] > maxlat) maxlat = lat[i];
                        e_sh = e_sh | hit_cfg[i];
                        dty  = dty | dirty_cfg[i];
                    end
                end
            end
            e_snp = timed ? TO : maxlat + 2;
            if (!req_nodata[o]) begin
                if (dty) e_c2c = 1; else e_mem = 1;
            end
        end
        if (timed) exp_to = 1'b1;

        @(negedge clk);
        cyc = 0;
        while (gnt === '0 && cyc < 4) begin @(negedge clk); cyc++; end
        n_vec++;
        if (gnt !== eg || cyc != 0) begin
            n_err++;
            $display("FAIL grant: got %b after %0d extra cycles, expected %b at once", gnt, cyc, eg);
        end
        if (drop_owner) req[o] = 1'b0;

        snp = 0; mcs = 0; bad_gnt = 0; bad_snp = 0; bad_mem = 0; bad_flg = 0; seen_done = 0; cyc = 0;
        while (!seen_done && cyc < 100) begin
            if (gnt !== eg) bad_gnt++;
            if (snoop_out !== '0) begin
                snp++;
                if (snoop_out !== esnp || snoop_inv !== inv_o) bad_snp++;
            end else if (snoop_inv !== 1'b0) bad_snp++;
            if (mem_cs === 1'b1) begin
                mcs++;
                if (mem_rd !== !e_wr || mem_wr !== e_wr) bad_mem++;
            end else if (mem_rd !== 1'b0 || mem_wr !== 1'b0) bad_mem++;
            if (done !== '0) seen_done = 1;
            else if (shared !== 1'b0 || c2c !== 1'b0) bad_flg++;
            for (int i = 0; i < NC; i++) begin
                if (i == o) begin
                    snoop_ready_in[i] = owner_junk && (snoop_out !== '0);
                    snoop_hit_in[i]   = snoop_ready_in[i];
                    snoop_dirty_in[i] = snoop_ready_in[i];
                end else begin
                    snoop_ready_in[i] = snoop_out[i] && (snp > lat[i]);
                    snoop_hit_in[i]   = snoop_ready_in[i] && hit_cfg[i];
                    snoop_dirty_in[i] = snoop_ready_in[i] && dirty_cfg[i];
                end
            end
            mem_ready = mem_cs && (mcs > mem_lat);
            if (!seen_done) begin @(negedge clk); cyc++; end
        end

        n_vec++; if (!seen_done) begin n_err++; $display("FAIL done_wait: no done within %0d cycles, expected done for core %0d", cyc, o); end
        n_vec++; if (done !== eg) begin n_err++; $display("FAIL done: got %b expected %b", done, eg); end
        n_vec++; if (shared !== e_sh) begin n_err++; $display("FAIL shared: got %b expected %b (owner %0d)", shared, e_sh, o); end
        n_vec++; if (c2c !== e_c2c) begin n_err++; $display("FAIL c2c: got %b expected %b (owner %0d)", c2c, e_c2c, o); end
        n_vec++; if (snp != e_snp) begin n_err++; $display("FAIL snoop_len: got %0d cycles expected %0d", snp, e_snp); end
        n_vec++; if (mcs != (e_mem ? mem_lat + 1 : 0)) begin n_err++; $display("FAIL mem_len: got %0d cycles expected %0d", mcs, e_mem ? mem_lat + 1 : 0); end
        n_vec++;
        if (bad_gnt + bad_snp + bad_mem + bad_flg != 0) begin
            n_err++;
            $display("FAIL protocol: bad cycles gnt=%0d snoop=%0d mem=%0d flags=%0d, required all 0", bad_gnt, bad_snp, bad_mem, bad_flg);
        end
        n_vec++; if (snoop_to !== exp_to) begin n_err++; $display("FAIL snoop_to: got %b expected %b", snoop_to, exp_to); end
        if (!keep_req) req[o] = 1'b0;
        exp_rr = (o + 1) % NC;
        @(negedge clk);
        n_vec++;
        if (gnt !== '0 || snoop_out !== '0 || mem_cs !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || done !== '0) begin
            n_err++;
            $display("FAIL idle: gnt=%b snoop_out=%b mem=%b%b%b done=%b, expected all 0", gnt, snoop_out, mem_cs, mem_rd, mem_wr, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_req('1, '0, '1, '0);
        repeat (3) @(negedge clk);
        n_vec++; if ({gnt, snoop_out, done} !== '0) begin n_err++; $display("FAIL reset_vec: gnt=%b snoop_out=%b done=%b expected 0", gnt, snoop_out, done); end
        n_vec++;
        if ({snoop_inv, mem_cs, mem_rd, mem_wr, shared, c2c, snoop_to} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_bits: got %b expected 0000000", {snoop_inv, mem_cs, mem_rd, mem_wr, shared, c2c, snoop_to});
        end
        set_req('0, '0, '0, '0);
        reset = 1'b1; exp_rr = 0; exp_to = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (gnt !== '0) begin n_err++; $display("FAIL idle_no_req: gnt=%b expected 0", gnt); end
    endtask

    task automatic test_round_robin();
        set_req('1, '0, '0, '0);
        set_resp(0, 0, 0, 0, '0, '0, 0);
        for (int t = 0; t < 5; t++) do_txn(1'b1, 1'b0);
        req = '0;
    endtask

    task automatic test_read_miss();
        set_req(4'b0001, '0, '0, '0);
`ifdef SNOOP_TIMEOUT_EN
        set_resp(0, 1, 0, 0, '0, '0, 2);
`else
        set_resp(0, 2, 0, 0, '0, '0, 2);
`endif
        do_txn(1'b0, 1'b1);
    endtask

    task automatic test_c2c();
        set_req(4'b0100, '0, '0, '0);
        set_resp(1, 0, 0, 0, 4'b0001, 4'b0001, 0);
        owner_junk = 1'b1;
        do_txn(1'b0, 1'b0);
        owner_junk = 1'b0;
    endtask

    task automatic test_upgrade();
        set_req(4'b0010, '0, 4'b0010, 4'b0010);
        set_resp(0, 0, 1, 0, 4'b0101, '0, 0);
        do_txn(1'b0, 1'b0);
    endtask

    task automatic test_writeback();
        set_req(4'b1000, 4'b1000, '0, '0);
        set_resp(0, 0, 0, 0, '1, '1, 3);
        do_txn(1'b0, 1'b0);
    endtask

`ifdef SNOOP_TIMEOUT_EN
    task automatic test_timeout();
        set_req(4'b0001, '0, '0, '0);
        set_resp(0, NEVER, 0, 0, 4'b0010, '0, 1);
        do_txn(1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        set_req('0, '0, '0, '0);
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NC; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i]        = 1'b1;
                    req_wr[i]     = ($urandom_range(0, 3) == 0);
                    req_inv[i]    = ($urandom_range(0, 1) == 1);
                    req_nodata[i] = req_inv[i] && ($urandom_range(0, 1) == 1);
                end
            end
            if (req == '0) begin
                req[t % NC] = 1'b1; req_wr[t % NC] = 1'b0;
                req_inv[t % NC] = 1'b0; req_nodata[t % NC] = 1'b0;
            end
            for (int i = 0; i < NC; i++) begin
`ifdef SNOOP_TIMEOUT_EN
                lat[i] = ($urandom_range(0, 3) == 3) ? NEVER : int'($urandom_range(0, 1));
`else
                lat[i] = int'($urandom_range(0, 4));
`endif
                hit_cfg[i]   = ($urandom_range(0, 1) == 1);
                dirty_cfg[i] = hit_cfg[i] && ($urandom_range(0, 2) == 0);
            end
            mem_lat    = int'($urandom_range(0, 3));
            owner_junk = ($urandom_range(0, 1) == 1);
            do_txn(1'b0, $urandom_range(0, 1) == 1);
        end
        req = '0; owner_junk = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        int cyc;
        bit saw_done;
        set_req(4'b0001, 4'b0001, '0, '0);
        mem_ready = 1'b0;
        cyc = 0;
        while (mem_cs !== 1'b1 && cyc < 5) begin @(negedge clk); cyc++; end
        n_vec++; if (mem_cs !== 1'b1) begin n_err++; $display("FAIL reach_mem: mem_cs=%b expected 1", mem_cs); end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (mem_cs !== 1'b0 || mem_wr !== 1'b0 || gnt !== '0) begin
            n_err++;
            $display("FAIL reset_async: mem_cs=%b mem_wr=%b gnt=%b expected 0 0 0", mem_cs, mem_wr, gnt);
        end
        n_vec++; if (snoop_to !== 1'b0) begin n_err++; $display("FAIL reset_snoop_to: got %b expected 0", snoop_to); end
        saw_done = 0;
        repeat (3) begin @(negedge clk); if (done !== '0) saw_done = 1; end
        n_vec++; if (saw_done) begin n_err++; $display("FAIL reset_done: done pulse seen, expected none"); end
        set_req(4'b1010, '0, '0, '0);
        set_resp(0, 0, 0, 0, '0, '0, 1);
        reset = 1'b1; exp_rr = 0; exp_to = 1'b0;
        do_txn(1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        set_req('0, '0, '0, '0);
        snoop_hit_in = '0; snoop_dirty_in = '0; snoop_ready_in = '0; mem_ready = 1'b0;
        set_resp(0, 0, 0, 0, '0, '0, 0);
        test_reset();
        test_round_robin();
        test_read_miss();
        test_c2c();
        test_upgrade();
        test_writeback();
`ifdef SNOOP_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/snoop_bus_ctrl.md
SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

Interface
REQ-001 SHALL have parameter NCORES, default 2, number of cache cores (legal 2..8).
REQ-002 SHALL have parameter TO_CYC, default 15, snoop timeout in cycles (legal 1..255).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  in  NCORES  per-core bus request, level.
REQ-006 SHALL have port req_wr  in  NCORES  1 = writeback to memory, 0 = fill.
REQ-007 SHALL have port req_inv  in  NCORES  1 = invalidating request (write miss/upgrade).
REQ-008 SHALL have port req_nodata  in  NCORES  1 = upgrade only, no data transfer.
REQ-009 SHALL have port gnt  out  NCORES  one-hot bus grant.
REQ-010 SHALL have port snoop_out  out  NCORES  snoop strobe to each non-owner core.
REQ-011 SHALL have port snoop_inv  out  1  current snoop is invalidating.
REQ-012 SHALL have port snoop_hit_in  in  NCORES  core holds line.
REQ-013 SHALL have port snoop_dirty_in  in  NCORES  core holds line Modified and drives data.
REQ-014 SHALL have port snoop_ready_in  in  NCORES  core has finished its snoop response.
REQ-015 SHALL have ports mem_cs, mem_rd, mem_wr  out  1 each  and mem_ready  in  1  memory handshake.
REQ-016 SHALL have port done  out  NCORES  one-cycle completion pulse to owner.
REQ-017 SHALL have ports shared  out  1 (another core hit), c2c  out  1 (data came from a cache), snoop_to  out  1 (sticky timeout flag).

Function
REQ-018 SHALL implement FSM states IDLE, SNOOP, MEM, DONE.
REQ-019 IDLE: if any req bit set, SHALL grant the first requester at or after rr_ptr (round-robin, wrapping NCORES-1 -> 0) and latch its req_wr/req_inv/req_nodata; 1 cycle IDLE -> next state.
REQ-020 Granted writeback (req_wr=1) SHALL go IDLE -> MEM, no snoop.
REQ-021 Otherwise SHALL go IDLE -> SNOOP; snoop_out = all cores except owner, held level; snoop_inv = latched req_inv.
REQ-022 SNOOP SHALL collect snoop_ready_in, snoop_hit_in and snoop_dirty_in into sticky per-core registers; owner bit ignored.
REQ-023 SNOOP SHALL exit the cycle after all non-owner ready bits are collected.
REQ-024 On SNOOP exit: req_nodata=1 -> DONE; any dirty bit -> DONE with c2c=1; else -> MEM (mem_rd).
REQ-025 MEM SHALL hold mem_cs=1 and mem_rd or mem_wr=1 until mem_ready=1, then -> DONE next cycle.
REQ-026 DONE SHALL pulse done[owner] 1 cycle, drop gnt, set rr_ptr = owner+1 modulo NCORES, -> IDLE.
REQ-027 shared and c2c SHALL be valid during DONE and 0 otherwise.
REQ-028 gnt SHALL stay one-hot and stable from grant through DONE; at most one transaction in flight.
REQ-029 Owner deasserting req mid-transaction SHALL be ignored; transaction completes.
REQ-030 Requests arriving during a transaction SHALL wait; none lost while req held.
REQ-031 snoop_out, mem_* and done SHALL be 0 in IDLE.

Reset
REQ-032 reset low SHALL immediately force state IDLE, rr_ptr 0, sticky registers 0, and all outputs 0, including snoop_to.
REQ-033 Reset mid-transaction SHALL abandon it with no done pulse; first grant after release goes to the lowest-index requester.

Configuration
REQ-034 Macro SNOOP_TIMEOUT_EN SHALL control the snoop timeout.
REQ-035 Defined: SNOOP counts cycles; at TO_CYC without all ready, missing cores count as miss/clean, snoop_to sets (sticky until reset), exit per REQ-024.
REQ-036 Undefined: SNOOP waits indefinitely; snoop_to tied 0; no counter logic.

Verification
REQ-037 NCORES=2, core0 read, core1 ready 2 cycles later with hit=0 -> mem_rd until mem_ready, done[0] pulse, shared=0, c2c=0.
REQ-038 NCORES=4, core2 read, core0 hit+dirty -> no mem_cs, done[2] with c2c=1, shared=1.
REQ-039 NCORES=4, all req held high -> grants 0,1,2,3,0 in order, each one-hot.
REQ-040 Core1 upgrade (req_inv=1, req_nodata=1) -> snoop_inv=1 to cores 0,2,3, done[1] with no memory access.
REQ-041 SNOOP_TIMEOUT_EN, TO_CYC=3, core1 never ready -> exit after 3 cycles, snoop_to=1, memory read issued.
REQ-042 reset low during MEM -> mem_cs/gnt 0 the same cycle, no done pulse; after release, req=4'b1010 grants core1.
